// File: rtl/neuron_learn_layer_seq.sv
// neuron_learn_layer_seq: sequential M x N neuron layer, one MAC per clock,
// with an optional delta-rule weight pass and back-propagated input targets.
module neuron_learn_layer_seq #(
  parameter int N = 16,
  parameter int M = 27,
  parameter int W = 8,
  parameter int WW = 16,
  parameter int LR_SHIFT = 4,
  localparam int MN = M * N,
  localparam int AB = (MN > 1) ? $clog2(MN) : 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            learn,
  input  logic [N*W-1:0]  in,
  input  logic [M*W-1:0]  expected_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [M*W-1:0]  out,
  output logic [N*W-1:0]  expected_in,
  input  logic            w_wr_en,
  input  logic [AB-1:0]   w_addr,
  input  logic [WW-1:0]   w_wr_data,
  output logic [WW-1:0]   w_rd_data
);

  localparam int FB = WW - 4;
  localparam int NB = (N > 1) ? $clog2(N) : 1;
  localparam int MB = (M > 1) ? $clog2(M) : 1;
  localparam int AW = W + WW + $clog2(N) + 2;
  localparam int EW = 2 * W + WW + 4;
  localparam int SW = EW + MB + 1;
  localparam int SH_UPD = 2 * W - FB + LR_SHIFT;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] FWD  = 3'd1;
  localparam logic [2:0] UPD  = 3'd2;
  localparam logic [2:0] FIN  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [NB-1:0] N_LAST = NB'(N - 1);
  localparam logic [AB-1:0] P_LAST = AB'(MN - 1);
  localparam logic [AB:0] MN_X = (AB + 1)'(MN);
  localparam logic signed [AW-1:0] A_BIAS = AW'(1 << (W - 1));
  localparam logic signed [AW-1:0] A_MAX = AW'((1 << W) - 1);
  localparam logic signed [EW-1:0] W_MAX = EW'((1 << (WW - 1)) - 1);
  localparam logic signed [EW-1:0] W_MIN = -W_MAX - EW'(1);
  localparam logic signed [SW-1:0] S_MAX = SW'((1 << W) - 1);
  localparam logic signed [SW-1:0] S_DIV = SW'(M);

  if (2 * W < FB) begin : g_bad_fmt
    $error("neuron_learn_layer_seq: 2*W must be >= WW-4");
  end

  logic [2:0] state;
  logic [AB-1:0] pos;
  logic [MB-1:0] m_idx;
  logic [NB-1:0] n_idx;
  logic run;
  logic learn_r;

  logic [W-1:0] in_r [N];
  logic [W-1:0] exp_r [M];
  logic [W-1:0] out_r [M];
  logic [W-1:0] ein_r [N];
  logic signed [SW-1:0] sum [N];
  logic signed [WW-1:0] wt [MN];
  logic signed [AW-1:0] acc;

  logic [W-1:0] cur_in, cur_exp, cur_out;
  logic signed [WW-1:0] w_old;

  assign cur_in  = in_r[n_idx];
  assign cur_exp = exp_r[m_idx];
  assign cur_out = out_r[m_idx];
  assign w_old   = wt[pos];

  assign run       = (state == FWD) || (state == UPD);
  assign in_ready  = (state == IDLE) && !w_wr_en;
  assign out_valid = (state == DONE);
  assign w_rd_data = ({1'b0, w_addr} < MN_X) ? wt[w_addr] : '0;

  for (genvar g = 0; g < M; g++) begin : g_out
    assign out[g*W +: W] = out_r[g];
  end

  for (genvar g = 0; g < N; g++) begin : g_ein
    assign expected_in[g*W +: W] = ein_r[g];
  end

  logic signed [AW-1:0] prod, acc_nxt, act_b;
  logic [W-1:0] act;

  always_comb begin
    prod = AW'($signed({1'b0, cur_in})) * AW'(w_old);
    acc_nxt = ((n_idx == '0) ? AW'(0) : acc) + prod;
    act_b = ((acc_nxt >>> FB) >>> 1) + A_BIAS;
    if (act_b[AW-1]) act = '0;
    else if (act_b > A_MAX) act = '1;
    else act = act_b[W-1:0];
  end

  logic signed [W:0] err;
  logic signed [EW-1:0] ex, wx, ix, back, delta, wsum;
  logic signed [WW-1:0] w_new;
  logic signed [SW-1:0] sum_nxt;

  always_comb begin
    err = $signed({1'b0, cur_exp}) - $signed({1'b0, cur_out});
    ex = EW'(err);
    wx = EW'(w_old);
    ix = EW'($signed({1'b0, cur_in}));
    back = (ex * wx) >>> FB;
    delta = (ex * ix) >>> SH_UPD;
    wsum = wx + delta;
    if (wsum > W_MAX) w_new = W_MAX[WW-1:0];
    else if (wsum < W_MIN) w_new = W_MIN[WW-1:0];
    else w_new = wsum[WW-1:0];
    sum_nxt = sum[n_idx] + SW'(back);
  end

  // sum/M truncates toward zero: signed division by a constant
  logic [W-1:0] fin_val [N];
  logic signed [SW-1:0] fin_t;

  always_comb begin
    fin_t = '0;
    for (int i = 0; i < N; i++) begin
      fin_t = sum[i] / S_DIV + SW'($signed({1'b0, in_r[i]}));
      if (fin_t[SW-1]) fin_val[i] = '0;
      else if (fin_t > S_MAX) fin_val[i] = '1;
      else fin_val[i] = fin_t[W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pos <= '0;
      m_idx <= '0;
      n_idx <= '0;
    end else if (!run || pos == P_LAST) begin
      pos <= '0;
      m_idx <= '0;
      n_idx <= '0;
    end else begin
      pos <= pos + AB'(1);
      if (n_idx == N_LAST) begin
        n_idx <= '0;
        m_idx <= m_idx + MB'(1);
      end else begin
        n_idx <= n_idx + NB'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc <= '0;
      learn_r <= 1'b0;
      for (int i = 0; i < N; i++) begin
        in_r[i] <= '0;
        ein_r[i] <= '0;
        sum[i] <= '0;
      end
      for (int i = 0; i < M; i++) begin
        exp_r[i] <= '0;
        out_r[i] <= '0;
      end
      for (int i = 0; i < MN; i++) begin
        wt[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (w_wr_en) begin
            if ({1'b0, w_addr} < MN_X) wt[w_addr] <= w_wr_data;
          end else if (in_valid) begin
            learn_r <= learn;
            for (int i = 0; i < N; i++) begin
              in_r[i] <= in[i*W +: W];
              sum[i] <= '0;
            end
            for (int i = 0; i < M; i++) begin
              exp_r[i] <= expected_out[i*W +: W];
            end
            state <= FWD;
          end
        end
        FWD: begin
          acc <= acc_nxt;
          if (n_idx == N_LAST) out_r[m_idx] <= act;
          if (pos == P_LAST) begin
            state <= learn_r ? UPD : DONE;
            if (!learn_r) begin
              for (int i = 0; i < N; i++) ein_r[i] <= in_r[i];
            end
          end
        end
        UPD: begin
          wt[pos] <= w_new;
          sum[n_idx] <= sum_nxt;
          if (pos == P_LAST) state <= FIN;
        end
        FIN: begin
          for (int i = 0; i < N; i++) ein_r[i] <= fin_val[i];
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_learn_layer_seq.sv
// tb_neuron_learn_layer_seq: directed corner cases plus randomized layers
// checked against an integer-arithmetic model of the layer.
module tb_neuron_learn_layer_seq;
  localparam int N = 16;
  localparam int M = 27;
  localparam int W = 8;
  localparam int WW = 16;
  localparam int LR_SHIFT = 4;
  localparam int FB = WW - 4;
  localparam int MN = M * N;
  localparam int AB = $clog2(MN);

  logic clock = 0;
  logic reset_n = 1;
  logic in_valid = 0;
  logic learn = 0;
  logic out_ready = 0;
  logic w_wr_en = 0;
  logic in_ready, out_valid;
  logic [N*W-1:0] in_bus = '0;
  logic [M*W-1:0] eo_bus = '0;
  logic [M*W-1:0] out_bus;
  logic [N*W-1:0] ei_bus;
  logic [AB-1:0] w_addr = '0;
  logic [WW-1:0] w_wr_data = '0;
  logic [WW-1:0] w_rd_data;

  always #5 clock = ~clock;

  neuron_learn_layer_seq #(
    .N(N), .M(M), .W(W), .WW(WW), .LR_SHIFT(LR_SHIFT)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .learn(learn),
    .in(in_bus),
    .expected_out(eo_bus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out_bus),
    .expected_in(ei_bus),
    .w_wr_en(w_wr_en),
    .w_addr(w_addr),
    .w_wr_data(w_wr_data),
    .w_rd_data(w_rd_data)
  );

  int checks = 0;
  int fails = 0;
  longint mw [MN];
  int vin [N];
  int vexp [M];
  longint mout [M];
  longint mein [N];

  task automatic chk(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint fdiv(longint a, longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && ((a < 0) != (d < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint clampv(longint v, longint lo, longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_op(bit lrn);
    longint acc, e;
    longint sums [N];
    for (int m = 0; m < M; m++) begin
      acc = 0;
      for (int n = 0; n < N; n++) acc += vin[n] * mw[m*N+n];
      mout[m] = clampv(fdiv(acc, 1 << (FB + 1)) + (1 << (W - 1)), 0, (1 << W) - 1);
    end
    if (lrn) begin
      for (int n = 0; n < N; n++) sums[n] = 0;
      for (int m = 0; m < M; m++) begin
        e = vexp[m] - mout[m];
        for (int n = 0; n < N; n++) begin
          sums[n] += fdiv(e * mw[m*N+n], 1 << FB);
          mw[m*N+n] = clampv(mw[m*N+n] + fdiv(e * vin[n], 1 << (2*W - FB + LR_SHIFT)),
                             -(1 << (WW-1)), (1 << (WW-1)) - 1);
        end
      end
      for (int n = 0; n < N; n++) mein[n] = clampv(vin[n] + sums[n] / M, 0, (1 << W) - 1);
    end else begin
      for (int n = 0; n < N; n++) mein[n] = vin[n];
    end
  endtask

  task automatic pack();
    for (int n = 0; n < N; n++) in_bus[n*W +: W] = W'(vin[n]);
    for (int m = 0; m < M; m++) eo_bus[m*W +: W] = W'(vexp[m]);
  endtask

  task automatic clear_vec(int iv, int ev);
    for (int n = 0; n < N; n++) vin[n] = iv;
    for (int m = 0; m < M; m++) vexp[m] = ev;
  endtask

  task automatic do_reset();
    @(negedge clock);
    in_valid = 0;
    w_wr_en = 0;
    out_ready = 0;
    reset_n = 0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_zero", longint'(out_bus == '0), 1);
    chk("rst_ein_zero", longint'(ei_bus == '0), 1);
    @(negedge clock);
    reset_n = 1;
    for (int i = 0; i < MN; i++) mw[i] = 0;
  endtask

  task automatic wr(int a, longint d);
    @(negedge clock);
    w_wr_en = 1;
    w_addr = AB'(a);
    w_wr_data = WW'(d);
    @(negedge clock);
    w_wr_en = 0;
    mw[a] = d;
  endtask

  task automatic chk_w(string tag, int a);
    w_addr = AB'(a);
    #1;
    chk($sformatf("%s_w%0d", tag, a), longint'($signed(w_rd_data)), mw[a]);
  endtask

  task automatic chk_all_w(string tag);
    @(negedge clock);
    for (int a = 0; a < MN; a++) chk_w(tag, a);
  endtask

  task automatic run_op(bit lrn, int hold);
    int cyc, lat;
    @(negedge clock);
    pack();
    learn = lrn;
    in_valid = 1;
    #1;
    chk("acc_in_ready", in_ready, 1);
    model_op(lrn);
    @(posedge clock);
    #1;
    in_valid = 0;
    lat = lrn ? 2 * MN + 1 : MN;
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
    end while (!out_valid && cyc < 3 * MN);
    chk("latency", cyc, lat);
    for (int m = 0; m < M; m++) chk($sformatf("out%0d", m), out_bus[m*W +: W], mout[m]);
    for (int n = 0; n < N; n++) chk($sformatf("ein%0d", n), ei_bus[n*W +: W], mein[n]);
    for (int h = 0; h < hold; h++) begin
      w_wr_en = h[0];
      w_addr = '0;
      w_wr_data = WW'(~mw[0]);
      @(posedge clock);
      #1;
      chk("hold_valid", out_valid, 1);
      if (!h[0]) chk("hold_in_ready", in_ready, 0);
      chk("hold_out0", out_bus[0 +: W], mout[0]);
      chk("hold_ein0", ei_bus[0 +: W], mein[0]);
      chk("hold_wr_ignored", longint'($signed(w_rd_data)), mw[0]);
    end
    w_wr_en = 0;
    out_ready = 1;
    @(posedge clock);
    #1;
    out_ready = 0;
    chk("drop_valid", out_valid, 0);
    chk("keep_out0", out_bus[0 +: W], mout[0]);
  endtask

  initial begin
    do_reset();
    for (int a = 0; a < 8; a++) chk_w("rst", a);

    clear_vec(100, 0);
    run_op(0, 0);

    wr(0, 4096);
    clear_vec(0, 0);
    vin[0] = 255;
    run_op(0, 0);
    chk("unit_out0", out_bus[0 +: W], 255);
    chk("unit_out1", out_bus[W +: W], 128);

    do_reset();
    clear_vec(0, 128);
    vin[0] = 255;
    vexp[0] = 255;
    run_op(1, 0);
    chk("learn_ein0", ei_bus[0 +: W], 255);
    chk_all_w("learn");
    w_addr = '0;
    #1;
    chk("learn_w00", longint'($signed(w_rd_data)), 126);

    do_reset();
    wr(0, 32767);
    wr(1, -32768);
    clear_vec(0, 128);
    vin[0] = 255;
    vin[1] = 255;
    vexp[0] = 254;
    run_op(1, 10);
    @(negedge clock);
    w_addr = '0;
    #1;
    chk("sat_pos_w00", longint'($signed(w_rd_data)), 32767);

    wr(0, -32768);
    wr(1, 32767);
    vexp[0] = 0;
    run_op(1, 0);
    @(negedge clock);
    w_addr = '0;
    #1;
    chk("sat_neg_w00", longint'($signed(w_rd_data)), -32768);
    chk_all_w("sat");

    @(negedge clock);
    in_valid = 1;
    w_wr_en = 1;
    w_addr = AB'(5);
    w_wr_data = WW'(1234);
    #1;
    chk("wr_blocks_ready", in_ready, 0);
    @(negedge clock);
    in_valid = 0;
    w_wr_en = 0;
    mw[5] = 1234;
    chk_w("wrv", 5);
    repeat (3) @(negedge clock);
    chk("wrv_not_accepted", in_ready, 1);
    chk("wrv_no_valid", out_valid, 0);

    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < MN; a++) wr(a, longint'($urandom_range(0, 1200)) - 600);
      for (int n = 0; n < N; n++) vin[n] = $urandom_range(0, 255);
      for (int m = 0; m < M; m++) vexp[m] = $urandom_range(0, 255);
      run_op(t % 3 != 0, (t == 2) ? 4 : 0);
      if (t % 3 != 0) chk_all_w($sformatf("rnd%0d", t));
    end

    @(negedge clock);
    for (int n = 0; n < N; n++) vin[n] = $urandom_range(0, 255);
    pack();
    learn = 1;
    in_valid = 1;
    @(posedge clock);
    #1;
    in_valid = 0;
    repeat (MN + 20) @(posedge clock);
    #2;
    reset_n = 0;
    #1;
    chk("midupd_valid", out_valid, 0);
    chk("midupd_in_ready", in_ready, 1);
    @(negedge clock);
    reset_n = 1;
    for (int i = 0; i < MN; i++) mw[i] = 0;
    chk_all_w("midupd");
    repeat (3 * MN) @(negedge clock);
    chk("midupd_stay_idle", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
